// File: rtl/remap_stream_stage.sv
// Streaming wrapper for the remap datapath: registered input stage feeding an external
// combinational core, whose result lands one cycle later in a show-ahead, credit-guarded FIFO.
module remap_stream_stage #(
    parameter int NUM_LENGTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [NUM_LENGTH-1:0] num_i,
    output logic [NUM_LENGTH-1:0] core_num_o,
    input  logic [NUM_LENGTH-1:0] core_rslt_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NUM_LENGTH-1:0] rslt_o,
    output logic [CNT_W-1:0]      count_o
);

    logic                  r_s1_valid;
    logic [NUM_LENGTH-1:0] r_core_num;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [NUM_LENGTH-1:0] r_mem [DEPTH];

    logic [CNT_W:0]        w_occupancy;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_out_valid;
    logic                  w_pop;

    // The in-flight operand already owns a slot, so it counts against the credit.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
    assign w_ready     = w_occupancy < (CNT_W + 1)'(DEPTH);
    assign w_accept    = in_valid_i & w_ready;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_core_num <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_core_num <= num_i;
            end
            if (r_s1_valid) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({r_s1_valid, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; an empty FIFO never exposes it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && r_s1_valid) begin
            r_mem[r_wr_ptr] <= core_rslt_i;
        end
    end

    a_no_capture_when_full: assert property (
        @(posedge clk_i) disable iff (rst_i)
        r_s1_valid |-> (r_count != CNT_W'(DEPTH))
    );

    assign in_ready_o  = w_ready;
    assign core_num_o  = r_core_num;
    assign out_valid_o = w_out_valid;
    assign rslt_o      = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign count_o     = r_count;

endmodule

// File: tb/tb_remap_stream_stage.sv
// Randomized bench for remap_stream_stage: a queue-based reference of the stage, with a
// stand-in combinational core driven from core_num_o.
module tb_remap_stream_stage;

    localparam int NL    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [NL-1:0] num_i;
    logic [NL-1:0] core_num_o;
    logic [NL-1:0] core_rslt_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [NL-1:0] rslt_o;
    logic [CNT_W-1:0] count_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: results held in the FIFO plus the single operand in flight.
    logic [NL-1:0] q[$];
    bit            infl;
    logic [NL-1:0] infl_v;
    logic [NL-1:0] exp_core;
    bit            model_ok;
    int            acc_cnt;
    int            dut_acc_cnt;
    int            dut_pop_cnt;
    int            max_cnt;

    function automatic logic [NL-1:0] core_f(input logic [NL-1:0] x);
        return (x * 32'h9E37_79B1) ^ {x[15:0], x[31:16]};
    endfunction

    assign core_rslt_i = core_f(core_num_o);

    remap_stream_stage #(.NUM_LENGTH(NL), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .num_i       (num_i),
        .core_num_o  (core_num_o),
        .core_rslt_i (core_rslt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .rslt_o      (rslt_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs against the reference, advance both.
    task automatic step(input bit v, input logic [NL-1:0] n, input bit rdy, input bit rst);
        bit exp_rdy;
        bit acc;
        bit pop;
        in_valid_i  = v;
        num_i       = n;
        out_ready_i = rdy;
        rst_i       = rst;
        #1;
        exp_rdy = 1'b0;
        if (model_ok) begin
            exp_rdy = (q.size() + int'(infl)) < DEPTH;
            check("in_ready",  64'(in_ready_o),  64'(exp_rdy));
            check("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
            check("rslt",      64'(rslt_o),      64'((q.size() != 0) ? q[0] : '0));
            check("count",     64'(count_o),     64'(q.size()));
            check("core_num",  64'(core_num_o),  64'(exp_core));
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
        end
        if (!rst && v && in_ready_o)   dut_acc_cnt++;
        if (!rst && rdy && out_valid_o) dut_pop_cnt++;
        acc = v && exp_rdy && !rst;
        pop = rdy && (q.size() != 0) && !rst;
        @(posedge clk_i);
        if (rst) begin
            q.delete();
            infl     = 1'b0;
            exp_core = '0;
            model_ok = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (infl) q.push_back(infl_v);
            infl = acc;
            if (acc) begin
                infl_v   = core_f(n);
                exp_core = n;
                acc_cnt++;
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        int a0;
        int p0;
        int cyc;
        logic [NL-1:0] x;
        logic [NL-1:0] first;
        rst_i = 1'b1; in_valid_i = 1'b0; num_i = '0; out_ready_i = 1'b0;
        model_ok = 1'b0; infl = 1'b0; exp_core = '0;
        acc_cnt = 0; dut_acc_cnt = 0; dut_pop_cnt = 0; max_cnt = 0;
        @(negedge clk_i);

        // T1: reset held two cycles while an operand is offered
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        #1;
        check("t1_out_valid", 64'(out_valid_o), 64'(0));
        check("t1_rslt",      64'(rslt_o),      64'(0));
        check("t1_count",     64'(count_o),     64'(0));
        check("t1_core_num",  64'(core_num_o),  64'(0));
        step(1'b0, '0, 1'b0, 1'b0);

        // T2: single operand latency
        step(1'b1, 32'h0000_1000, 1'b0, 1'b0);
        check("t2_core_num", 64'(core_num_o), 64'(32'h0000_1000));
        check("t2_not_yet",  64'(out_valid_o), 64'(0));
        step(1'b0, '0, 1'b0, 1'b0);
        check("t2_valid", 64'(out_valid_o), 64'(1));
        check("t2_rslt",  64'(rslt_o),      64'(core_f(32'h0000_1000)));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // T3: fill with downstream stalled
        a0 = dut_acc_cnt;
        first = 32'h1111_0001;
        for (int i = 0; i < 8; i++) step(1'b1, first + 32'(i), 1'b0, 1'b0);
        check("t3_accepts", 64'(dut_acc_cnt - a0), 64'(4));
        check("t3_ready",   64'(in_ready_o), 64'(0));
        check("t3_count",   64'(count_o),    64'(4));
        check("t3_head",    64'(rslt_o),     64'(core_f(first)));

        // T4: one pop frees a credit on the following cycle
        step(1'b0, '0, 1'b1, 1'b0);
        check("t4_count", 64'(count_o),    64'(3));
        check("t4_ready", 64'(in_ready_o), 64'(1));
        a0 = dut_acc_cnt;
        step(1'b1, 32'h5555_0005, 1'b0, 1'b0);
        check("t4_accept5", 64'(dut_acc_cnt - a0), 64'(1));
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t4_drained", 64'(count_o), 64'(0));

        // T5: random streaming
        a0 = acc_cnt;
        p0 = dut_pop_cnt;
        max_cnt = 0;
        cyc = 0;
        while (acc_cnt - a0 < 64 && cyc < 3000) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
        end
        check("t5_all_accepted", 64'(acc_cnt - a0 >= 64), 64'(1));
        cyc = 0;
        while ((q.size() != 0 || infl) && cyc < 200) begin
            step(1'b0, '0, 1'b1, 1'b0);
            cyc++;
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("t5_drain_done", 64'(out_valid_o), 64'(0));
        check("t5_max_count",  64'(max_cnt <= DEPTH), 64'(1));
        check("t5_pops",       64'(dut_pop_cnt - p0), 64'(acc_cnt - a0));
        check("t5_wraps",      64'((dut_pop_cnt - p0) / DEPTH >= 10), 64'(1));

        // T6: reset with three results stored and one in flight
        for (int i = 0; i < 4; i++) step(1'b1, 32'h7700_0000 + 32'(i), 1'b0, 1'b0);
        check("t6_count3", 64'(count_o), 64'(3));
        step(1'b0, '0, 1'b0, 1'b1);
        check("t6_count0", 64'(count_o),     64'(0));
        check("t6_empty",  64'(out_valid_o), 64'(0));
        x = $urandom;
        step(1'b1, x, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t6_first_out", 64'(rslt_o),  64'(core_f(x)));
        check("t6_count1",    64'(count_o), 64'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
